fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction ROM for the pipelined CPU. It owns the fetch PC, drives the ROM address, and buffers fetched words in a 2-entry queue with a valid/ready handshake to decode. It flushes and retargets on branch redirects, and stops fetching with a sticky fault on misaligned or out-of-range PCs.

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch: drives the ROM from fetch_pc and buffers words in a 2-entry queue to decode.
// One cycle from fetch to out_*. A full, unpopped queue stalls fetch. Redirects flush the queue. Bad PCs raise a sticky fault.
module fetch_sequencer #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [63:0] fetch_pc, fetch_pc_nxt;
  logic [63:0] fault_pc_nxt;
  logic [1:0]  count;
  logic [63:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        pop, can_push, push, bad_pc;
  logic [64:0] pc_last;

  // Extra bit keeps the range check from wrapping near the top of the address space.
  assign pc_last  = {1'b0, fetch_pc} + 65'd3;
  assign bad_pc   = (fetch_pc[1:0] != 2'b00) || (pc_last >= 65'(MEM_SIZE));

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign can_push  = (count < 2'd2) || pop;
  assign out_instr = out_valid ? q_instr[0] : 32'd0;
  assign out_pc    = out_valid ? q_pc[0]    : 64'd0;
  assign fault     = (state == FAULT);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    fault_pc_nxt = fault_pc;
    push         = 1'b0;
    if (redirect) begin
      state_nxt    = RUN;
      fetch_pc_nxt = redirect_pc;
      fault_pc_nxt = 64'd0;
    end else if (state == RUN && can_push) begin
      if (bad_pc) begin
        state_nxt    = FAULT;
        fault_pc_nxt = fetch_pc;
      end else begin
        push         = 1'b1;
        fetch_pc_nxt = fetch_pc + 64'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault_pc <= 64'd0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  // Head always lives in slot 0; a pop shifts slot 1 forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= 64'd0;
        q_instr[i] <= 32'd0;
      end
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      if (push && pop) begin
        if (count == 2'd2) begin
          q_pc[0]    <= q_pc[1];
          q_instr[0] <= q_instr[1];
          q_pc[1]    <= fetch_pc;
          q_instr[1] <= imem_instr;
        end else begin
          q_pc[0]    <= fetch_pc;
          q_instr[0] <= imem_instr;
        end
      end else if (push) begin
        q_pc[count[0]]    <= fetch_pc;
        q_instr[count[0]] <= imem_instr;
        count             <= count + 2'd1;
      end else if (pop) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
        count      <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the ROM returns 0xBEEF0000 ^ address.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;
  logic [63:0] fault_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hBEEF_0000 ^ imem_addr[31:0] ^ imem_addr[63:32];

  fetch_sequencer #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    out_ready   = 1'b1;
    #3;
    check("rst_valid",    {63'd0, out_valid}, 64'd0);
    check("rst_fault",    {63'd0, fault},     64'd0);
    check("rst_faultpc",  fault_pc,           64'd0);
    check("rst_addr",     imem_addr,          64'd0);
    check("rst_pc",       out_pc,             64'd0);
    check("rst_instr",    {32'd0, out_instr}, 64'd0);
    #9 reset = 1'b0;
    check("rel_valid0",   {63'd0, out_valid}, 64'd0);

    // Streaming from reset: A,B,C,D
    tick(); check("s0_valid", {63'd0, out_valid}, 64'd1);
            check("s0_pc", out_pc, 64'h0); check("s0_in", {32'd0, out_instr}, 64'hBEEF_0000);
    tick(); check("s1_pc", out_pc, 64'h4); check("s1_in", {32'd0, out_instr}, 64'hBEEF_0004);
    tick(); check("s2_pc", out_pc, 64'h8); check("s2_in", {32'd0, out_instr}, 64'hBEEF_0008);
    tick(); check("s3_pc", out_pc, 64'hC); check("s3_in", {32'd0, out_instr}, 64'hBEEF_000C);

    // Backpressure from reset
    out_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_head",  out_pc,             64'h0);
    check("bp_addr",  imem_addr,          64'h8);
    out_ready = 1'b1;
    tick(); check("bp_d1", out_pc, 64'h4);
    tick(); check("bp_d2", out_pc, 64'h8);
    tick(); check("bp_d3", out_pc, 64'hC);

    // Fill queue, then redirect while ready
    out_ready = 1'b0;
    tick(); check("rd_full_head", out_pc, 64'hC); check("rd_full_addr", imem_addr, 64'h14);
    redirect = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
    tick(); check("rd_valid0", {63'd0, out_valid}, 64'd0); check("rd_addr", imem_addr, 64'h40);
    redirect = 1'b0;
    tick(); check("rd_pc0", out_pc, 64'h40);
    tick(); check("rd_pc1", out_pc, 64'h44);

    // End of memory
    redirect = 1'b1; redirect_pc = 64'h3F8;
    tick(); check("em_valid0", {63'd0, out_valid}, 64'd0);
    redirect = 1'b0;
    tick(); check("em_pc0", out_pc, 64'h3F8); check("em_nofault", {63'd0, fault}, 64'd0);
    tick(); check("em_pc1", out_pc, 64'h3FC);
    tick(); check("em_fault", {63'd0, fault}, 64'd1); check("em_fpc", fault_pc, 64'h400);
            check("em_drained", {63'd0, out_valid}, 64'd0); check("em_outpc", out_pc, 64'd0);
    tick(); check("em_sticky", {63'd0, fault}, 64'd1); check("em_hold", imem_addr, 64'h400);

    // Misaligned fault and recovery
    redirect = 1'b1; redirect_pc = 64'h6;
    tick(); check("ma_clr", {63'd0, fault}, 64'd0); check("ma_clrpc", fault_pc, 64'd0);
    redirect = 1'b0;
    tick(); check("ma_fault", {63'd0, fault}, 64'd1); check("ma_fpc", fault_pc, 64'h6);
            check("ma_nopush", {63'd0, out_valid}, 64'd0);
    redirect = 1'b1; redirect_pc = 64'h10;
    tick(); check("rc_fault", {63'd0, fault}, 64'd0); check("rc_fpc", fault_pc, 64'd0);
    redirect = 1'b0;
    tick(); check("rc_pc", out_pc, 64'h10); check("rc_in", {32'd0, out_instr}, 64'hBEEF_0010);

    // Reset mid-stream with a full queue
    out_ready = 1'b0;
    tick(); check("mr_full_head", out_pc, 64'h10); check("mr_full_addr", imem_addr, 64'h18);
    reset = 1'b1;
    #1;
    check("mr_valid", {63'd0, out_valid}, 64'd0);
    check("mr_fault", {63'd0, fault},     64'd0);
    check("mr_addr",  imem_addr,          64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
